alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Single-issue controller wrapping the 8-bit ALU datapath with a 4-entry register file.
- Accepts one 8-bit instruction at a time over a valid/ready handshake, reads operands, drives the ALU, writes the result back, and can emit a register value on a result stream.
- Sits between the tile I/O pins and the ALU core, so external logic issues instructions instead of driving raw operands.

Parameters:
DATA_W, 8, datapath and register width
NREGS, 4, register-file depth (fixed by the 2-bit register fields)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
ena  input  1  clock enable; when low all state holds and no handshake completes
i_valid  input  1  instruction valid
o_ready  output  1  sequencer can accept an instruction
i_instr  input  8  [2:0] op, [4:3] ra (also destination), [6:5] rb, [7] reserved (ignored)
i_imm  input  DATA_W  immediate for LDI, sampled with i_instr
o_res_valid  output  1  o_result holds an OUT value
i_res_ready  input  1  downstream accepts o_result
o_result  output  DATA_W  OUT data
o_busy  output  1  high in any state other than IDLE

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: state = IDLE; R0..R3 = 0; o_ready = 1; o_res_valid = 0; o_result = 0; o_busy = 0.
- Opcodes, writing Rra unless noted:
  - 000 OR: Rra|Rrb
  - 001 NAND: ~(Rra&Rrb)
  - 010 NOR: ~(Rra|Rrb)
  - 011 AND: Rra&Rrb
  - 100 ADD: Rra+Rrb, mod 2^DATA_W
  - 101 SUB: Rrb−Rra, mod 2^DATA_W
  - 110 LDI: Rra ← i_imm
  - 111 OUT: emit Rra; no register write
- States:
  - IDLE: o_ready = 1. Handshake is i_valid & o_ready & ena. On handshake, latch instr/imm, go to EXEC.
  - EXEC: read Rra/Rrb, compute, register result into r_alu. OUT goes to EMIT; all others go to WB.
  - WB: write r_alu to Rra, go to IDLE.
  - EMIT: o_res_valid = 1, o_result = r_alu, held stable until i_res_ready & ena, then go to IDLE. o_result holds its last value after o_res_valid falls.
- Latency: accept in cycle N; register updated at end of cycle N+2; next instruction accepted at earliest in cycle N+3. OUT: o_res_valid rises in cycle N+2.
- o_ready is low in EXEC/WB/EMIT, so there are no hazards. Back-to-back dependent instructions see the written value.
- ra == rb is legal. For example, SUB R1,R1 gives 0.
- i_instr[7] set: ignored, executes normally.
- ena low mid-operation: state freezes; resumes when ena returns.
- rst asserted in any state: immediate return to reset values. Any in-flight instruction or pending OUT is discarded.
- i_valid may drop without a handshake; the sequencer requires no stability from the upstream side.

Optional Feature:
Macro ALU_SEQ_FLAGS_EN.
- Defined:
  - Adds outputs o_zero (1 bit) and o_carry (1 bit), registered on each WB.
  - o_zero = (written value == 0).
  - o_carry = carry-out for ADD, borrow for SUB, 0 for logic ops and LDI.
  - OUT leaves both flags unchanged. Both reset to 0.
- Undefined: the ports and flag logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_OR..OP_OUT
  - instruction field offsets
  - state encoding typedef seq_state_t: IDLE, EXEC, WB, EMIT
- One sub-module alu_core: purely combinational, with inputs op, a, b and outputs y plus carry. The sequencer instantiates it.
- The register file stays inline in the sequencer.

Test Plan:
- Reset then OUT R2 with i_res_ready = 1 → o_result = 0x00, o_res_valid pulses for 1 cycle in cycle N+2; o_ready returns high in cycle N+3.
- LDI R0,0xF0; LDI R1,0x0F; OR R0,R1; OUT R0 → 0xFF. Then NAND R0,R1 (R0 = 0xFF, R1 = 0x0F); OUT R0 → 0xF0.
- LDI R2,0xC8; LDI R3,0x64; ADD R2,R3; OUT R2 → 0x2C. With ALU_SEQ_FLAGS_EN: o_carry = 1, o_zero = 0.
- LDI R0,0x05; LDI R1,0x03; SUB R0,R1 → R0 = 0xFE. Then SUB R1,R1 → R1 = 0x00; with flags, o_zero = 1.
- OUT with i_res_ready held low 5 cycles → o_res_valid and o_result stable and o_ready low throughout; completes on the first cycle i_res_ready = 1.
- Assert rst during EMIT, and separately during WB of LDI R3,0xAA → all outputs go to reset values immediately; a following OUT R3 returns 0x00.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: register-file depth, instruction
// field layout, opcode constants and the sequencer state encoding.
package alu_pkg;

    localparam int NREGS  = 4;

    localparam int OP_LSB = 0;
    localparam int OP_W   = 3;
    localparam int RA_LSB = 3;
    localparam int RB_LSB = 5;
    localparam int REG_W  = 2;

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_NOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_LDI  = 3'b110;
    localparam logic [2:0] OP_OUT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        EMIT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: logic ops, ADD (carry out), SUB b-a (borrow out),
// LDI passes b (the sequencer muxes the immediate onto b), OUT passes a.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    logic [DATA_W:0] wide;

    always_comb begin
        y     = a;
        carry = 1'b0;
        wide  = '0;
        case (op)
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_AND:  y = a & b;
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                y     = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            OP_SUB: begin
                // top bit of the extended difference is the borrow
                wide  = {1'b0, b} - {1'b0, a};
                y     = wide[DATA_W-1:0];
                carry = wide[DATA_W];
            end
            OP_LDI:  y = b;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue instruction sequencer around alu_core with a 4-entry register file.
// Optional zero/carry flag outputs are enabled with macro ALU_SEQ_FLAGS_EN.
module alu_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [7:0]        i_instr,
    input  logic [DATA_W-1:0] i_imm,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_busy
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic              o_zero,
    output logic              o_carry
`endif
);
    import alu_pkg::*;

    seq_state_t        state_reg, state_next;
    logic [6:0]        instr_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [DATA_W-1:0] alu_reg;
    logic [DATA_W-1:0] result_reg;
    logic              carry_pend_reg;
    logic [DATA_W-1:0] regs [NREGS];

    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  ra, rb;
    logic [DATA_W-1:0] opa, opb, alu_y;
    logic              alu_c;
    logic              accept;
    logic              instr_unused;

    // bit 7 of the instruction is reserved and deliberately dropped
    assign instr_unused = i_instr[7];

    assign op  = instr_reg[OP_LSB +: OP_W];
    assign ra  = instr_reg[RA_LSB +: REG_W];
    assign rb  = instr_reg[RB_LSB +: REG_W];
    assign opa = regs[ra];
    assign opb = (op == OP_LDI) ? imm_reg : regs[rb];

    alu_core #(.DATA_W(DATA_W)) u_core (
        .op    (op),
        .a     (opa),
        .b     (opb),
        .y     (alu_y),
        .carry (alu_c)
    );

    assign accept      = i_valid & ena & (state_reg == IDLE);
    assign o_ready     = (state_reg == IDLE);
    assign o_busy      = (state_reg != IDLE);
    assign o_res_valid = (state_reg == EMIT);
    assign o_result    = result_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = EXEC;
            EXEC: if (ena) state_next = (op == OP_OUT) ? EMIT : WB;
            WB:   if (ena) state_next = IDLE;
            EMIT: if (ena && i_res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            instr_reg      <= '0;
            imm_reg        <= '0;
            alu_reg        <= '0;
            result_reg     <= '0;
            carry_pend_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                instr_reg <= i_instr[6:0];
                imm_reg   <= i_imm;
            end
            if (ena && state_reg == EXEC) begin
                alu_reg        <= alu_y;
                carry_pend_reg <= alu_c;
                // o_result keeps the last emitted value until the next OUT
                if (op == OP_OUT)
                    result_reg <= alu_y;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (ena && state_reg == WB) begin
            regs[ra] <= alu_reg;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_zero  <= 1'b0;
            o_carry <= 1'b0;
        end else if (ena && state_reg == WB) begin
            o_zero  <= (alu_reg == '0);
            o_carry <= carry_pend_reg;
        end
    end
`else
    logic flags_unused;
    assign flags_unused = carry_pend_reg;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + randomized bench for alu_sequencer against a behavioural
// register-file model; flag checks compile in with ALU_SEQ_FLAGS_EN.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst, ena, i_valid, i_res_ready;
    logic       o_ready, o_res_valid, o_busy;
    logic [7:0] i_instr, i_imm, o_result;
`ifdef ALU_SEQ_FLAGS_EN
    logic       o_zero, o_carry;
`endif

    alu_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_instr     (i_instr),
        .i_imm       (i_imm),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_result    (o_result),
        .o_busy      (o_busy)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .o_zero      (o_zero),
        .o_carry     (o_carry)
`endif
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model_regs [4];
    logic [7:0] last_out;
    logic       model_z, model_c;

    localparam logic [2:0] M_OR = 3'd0, M_NAND = 3'd1, M_NOR = 3'd2, M_AND = 3'd3;
    localparam logic [2:0] M_ADD = 3'd4, M_SUB = 3'd5, M_LDI = 3'd6, M_OUT = 3'd7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("miscompare in %s", tag);
        end
    endtask

    function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] imm);
        int sum;
        case (op)
            M_OR:   return a | b;
            M_NAND: return ~(a & b);
            M_NOR:  return ~(a | b);
            M_AND:  return a & b;
            M_ADD:  begin sum = (int'(a) + int'(b)) % 256; return 8'(sum); end
            M_SUB:  begin sum = (int'(b) - int'(a) + 256) % 256; return 8'(sum); end
            M_LDI:  return imm;
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
        last_out = 8'h00;
        model_z  = 1'b0;
        model_c  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 1);
        check({tag, "_busy"}, 32'(o_busy), 0);
        check({tag, "_rvalid"}, 32'(o_res_valid), 0);
        check({tag, "_result"}, 32'(o_result), 0);
`ifdef ALU_SEQ_FLAGS_EN
        check({tag, "_zero"}, 32'(o_zero), 0);
        check({tag, "_carry"}, 32'(o_carry), 0);
`endif
    endtask

    // Called at a negedge with the sequencer idle; returns at a negedge, idle again.
    task automatic do_instr(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                            input logic [7:0] imm, input bit rsv, input int stall, input int gap);
        logic [7:0] a, b, expv;
        a    = model_regs[ra];
        b    = model_regs[rb];
        expv = ref_result(op, a, b, imm);
        $display("instr op=%0d ra=%0d rb=%0d imm=%02h rsv=%0d stall=%0d gap=%0d expect=%02h",
                 op, ra, rb, imm, rsv, stall, gap, expv);
        check("idle_ready", 32'(o_ready), 1);
        i_instr     = {rsv, rb, ra, op};
        i_imm       = imm;
        i_valid     = 1'b1;
        i_res_ready = (stall == 0);
        @(negedge clk);
        // upstream is free to change anything once the instruction is taken
        i_valid = 1'($urandom_range(0, 1));
        i_instr = 8'($urandom);
        i_imm   = 8'($urandom);
        check("exec_ready", 32'(o_ready), 0);
        check("exec_busy", 32'(o_busy), 1);
        check("exec_rvalid", 32'(o_res_valid), 0);
        if (gap > 0) begin
            ena = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                check("ena_hold_busy", 32'(o_busy), 1);
                check("ena_hold_ready", 32'(o_ready), 0);
                check("ena_hold_rvalid", 32'(o_res_valid), 0);
            end
            ena = 1'b1;
        end
        @(negedge clk);
        i_valid = 1'b0;
        if (op == M_OUT) begin
            check("out_valid", 32'(o_res_valid), 1);
            check("out_data", 32'(o_result), 32'(expv));
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                check("emit_hold_valid", 32'(o_res_valid), 1);
                check("emit_hold_data", 32'(o_result), 32'(expv));
                check("emit_hold_ready", 32'(o_ready), 0);
            end
            i_res_ready = 1'b1;
            last_out = expv;
        end else begin
            check("wb_rvalid", 32'(o_res_valid), 0);
            check("wb_ready", 32'(o_ready), 0);
            model_regs[ra] = expv;
            model_z = (expv == 8'h00);
            if (op == M_ADD)      model_c = (int'(a) + int'(b)) > 255;
            else if (op == M_SUB) model_c = (b < a);
            else                  model_c = 1'b0;
        end
        @(negedge clk);
        check("done_ready", 32'(o_ready), 1);
        check("done_busy", 32'(o_busy), 0);
        check("done_rvalid", 32'(o_res_valid), 0);
        check("done_result_held", 32'(o_result), 32'(last_out));
`ifdef ALU_SEQ_FLAGS_EN
        check("flag_zero", 32'(o_zero), 32'(model_z));
        check("flag_carry", 32'(o_carry), 32'(model_c));
`endif
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; i_valid = 1'b0; i_res_ready = 1'b0;
        i_instr = 8'h00; i_imm = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // handshake must not complete while ena is low
        ena = 1'b0; i_valid = 1'b1; i_instr = {3'b000, 2'd0, M_LDI}; i_imm = 8'h55;
        @(negedge clk);
        check("ena_low_no_accept", 32'(o_busy), 0);
        // valid withdrawn without a handshake
        i_valid = 1'b0; ena = 1'b1;
        @(negedge clk);
        check("valid_drop_idle", 32'(o_busy), 0);

        do_instr(M_OUT, 2'd2, 2'd0, 8'h00, 1'b0, 0, 0);
        do_instr(M_LDI, 2'd0, 2'd0, 8'hF0, 1'b0, 0, 0);
        do_instr(M_LDI, 2'd1, 2'd0, 8'h0F, 1'b0, 0, 0);
        do_instr(M_OR,  2'd0, 2'd1, 8'h00, 1'b0, 0, 0);
        do_instr(M_OUT, 2'd0, 2'd0, 8'h00, 1'b0, 0, 0);
        do_instr(M_NAND, 2'd0, 2'd1, 8'h00, 1'b0, 0, 0);
        do_instr(M_OUT, 2'd0, 2'd0, 8'h00, 1'b0, 0, 0);
        do_instr(M_LDI, 2'd2, 2'd0, 8'hC8, 1'b0, 0, 0);
        do_instr(M_LDI, 2'd3, 2'd0, 8'h64, 1'b0, 0, 0);
        do_instr(M_ADD, 2'd2, 2'd3, 8'h00, 1'b0, 0, 0);
        do_instr(M_OUT, 2'd2, 2'd0, 8'h00, 1'b1, 0, 0);
        do_instr(M_LDI, 2'd0, 2'd0, 8'h05, 1'b0, 0, 0);
        do_instr(M_LDI, 2'd1, 2'd0, 8'h03, 1'b0, 0, 0);
        do_instr(M_SUB, 2'd0, 2'd1, 8'h00, 1'b0, 0, 0);
        do_instr(M_OUT, 2'd0, 2'd0, 8'h00, 1'b0, 0, 0);
        do_instr(M_SUB, 2'd1, 2'd1, 8'h00, 1'b0, 0, 2);
        do_instr(M_OUT, 2'd1, 2'd0, 8'h00, 1'b0, 0, 0);
        do_instr(M_OUT, 2'd0, 2'd0, 8'h00, 1'b0, 5, 0);

        for (int n = 0; n < 40; n++) begin
            do_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     8'($urandom), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        // reset while an OUT is stalled in EMIT
        do_instr(M_LDI, 2'd1, 2'd0, 8'h3C, 1'b0, 0, 0);
        i_instr = {3'b000, 2'd1, M_OUT}; i_valid = 1'b1; i_res_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_emit_valid", 32'(o_res_valid), 1);
        check("pre_rst_emit_data", 32'(o_result), 32'h3C);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_emit");
        model_reset();
        @(negedge clk);
        rst = 1'b0; i_res_ready = 1'b1;
        @(negedge clk);
        do_instr(M_OUT, 2'd1, 2'd0, 8'h00, 1'b0, 0, 0);

        // reset during write-back of LDI R3,0xAA
        i_instr = {3'b000, 2'd3, M_LDI}; i_imm = 8'hAA; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_wb_busy", 32'(o_busy), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_wb");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_instr(M_OUT, 2'd3, 2'd0, 8'h00, 1'b0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
